// File: rtl/control_emulator.sv
// control_emulator: ngCCM control-block emulator for front-end bench testing.
// Conditions the asynchronous front-panel controls into the int_clk_in domain and
// drives them onward as levels (mode_select=0) or one-shot pulses (mode_select=1).
// Ports:
//   int_clk_in        system clock, all registers on its rising edge
//   reset_switch      asynchronous active-low reset
//   pgood             power-good input         -> penable
//   clk_select        clock source select      -> clk_out_p2 mux
//   mode_select       0 level / 1 pulse mode, also steers the clock mux
//   qie_reset_source  0 external qie_reset_in / 1 internal orbit generator
//   wte_in            warning-test-enable      -> wte_out
//   qie_reset_in      external QIE reset       -> qie_reset_out
//   aux_in            auxiliary line, idle 1   -> aux_out
//   ext_clk_in        external clock (mux data only)
//   clk_in_j1         J1 clock (mux data only)
//   reset_out         active-high reset stretched RESET_STRETCH clocks past release
// Optional build macro CTRL_EMU_PGOOD_GATE_EN gates wte_out and qie_reset_out with penable.
module control_emulator #(
    parameter int PULSE_LEN     = 4,
    parameter int ORBIT_LEN     = 16,
    parameter int RESET_STRETCH = 8
) (
    input  logic int_clk_in,
    input  logic reset_switch,
    input  logic pgood,
    input  logic clk_select,
    input  logic mode_select,
    input  logic qie_reset_source,
    input  logic wte_in,
    input  logic qie_reset_in,
    input  logic aux_in,
    input  logic ext_clk_in,
    input  logic clk_in_j1,
    output logic clk_out_p2,
    output logic qie_reset_out,
    output logic penable,
    output logic reset_out,
    output logic wte_out,
    output logic aux_out
);
    localparam logic [7:0]  PL = 8'(PULSE_LEN);
    localparam logic [7:0]  RS = 8'(RESET_STRETCH);
    localparam logic [15:0] OT = 16'(ORBIT_LEN - 1);

    // Synchronizer vectors: bit 0 = s1, bit 1 = s2, bit 2 = s3 (previous s2).
    logic [2:0]  w_s_q, w_s_d, q_s_q, q_s_d;
    logic [1:0]  a_s_q, a_s_d, p_s_q, p_s_d;
    logic [7:0]  w_cnt_q, w_cnt_d, q_cnt_q, q_cnt_d, str_q, str_d;
    logic [15:0] orb_q, orb_d;
    logic        rst_out_q, rst_out_d, wte_q, wte_d, qie_q, qie_d, aux_q, aux_d;

    always_comb begin
        w_s_d     = {w_s_q[1:0], wte_in};
        q_s_d     = {q_s_q[1:0], qie_reset_in};
        a_s_d     = {a_s_q[0], aux_in};
        p_s_d     = {p_s_q[0], pgood};
        // Leaving pulse mode kills any pulse; a rising edge (re)loads the counter.
        w_cnt_d   = !mode_select ? 8'd0 : (w_s_q[1] & ~w_s_q[2]) ? PL :
                    (w_cnt_q != 8'd0) ? w_cnt_q - 8'd1 : 8'd0;
        q_cnt_d   = !mode_select ? 8'd0 : (q_s_q[1] & ~q_s_q[2]) ? PL :
                    (q_cnt_q != 8'd0) ? q_cnt_q - 8'd1 : 8'd0;
        wte_d     = mode_select ? (w_cnt_d != 8'd0) : w_s_q[1];
        qie_d     = qie_reset_source ? (orb_q == OT) :
                    mode_select ? (q_cnt_d != 8'd0) : q_s_q[1];
        orb_d     = (orb_q == OT) ? 16'd0 : orb_q + 16'd1;
        str_d     = (str_q != 8'd0) ? str_q - 8'd1 : 8'd0;
        rst_out_d = str_d != 8'd0;
        aux_d     = a_s_q[1];
    end

    always_ff @(posedge int_clk_in or negedge reset_switch) begin
        if (!reset_switch) begin
            w_s_q     <= '0;
            q_s_q     <= '0;
            a_s_q     <= 2'b11;
            p_s_q     <= '0;
            w_cnt_q   <= '0;
            q_cnt_q   <= '0;
            orb_q     <= '0;
            str_q     <= RS;
            rst_out_q <= 1'b1;
            wte_q     <= 1'b0;
            qie_q     <= 1'b0;
            aux_q     <= 1'b1;
        end else begin
            w_s_q     <= w_s_d;
            q_s_q     <= q_s_d;
            a_s_q     <= a_s_d;
            p_s_q     <= p_s_d;
            w_cnt_q   <= w_cnt_d;
            q_cnt_q   <= q_cnt_d;
            orb_q     <= orb_d;
            str_q     <= str_d;
            rst_out_q <= rst_out_d;
            wte_q     <= wte_d;
            qie_q     <= qie_d;
            aux_q     <= aux_d;
        end
    end

    assign reset_out  = rst_out_q;
    assign penable    = p_s_q[1] & ~rst_out_q;
    assign aux_out    = aux_q;
    assign clk_out_p2 = mode_select ? clk_in_j1 : clk_select ? ext_clk_in : int_clk_in;
`ifdef CTRL_EMU_PGOOD_GATE_EN
    assign wte_out       = wte_q & penable;
    assign qie_reset_out = qie_q & penable;
`else
    assign wte_out       = wte_q;
    assign qie_reset_out = qie_q;
`endif
endmodule

// File: tb/tb_control_emulator.sv
// tb_control_emulator: directed self-checking bench for control_emulator.
module tb_control_emulator;
    logic clk = 1'b0;
    logic reset_switch = 1'b1;
    logic pgood = 1'b0, clk_select = 1'b0, mode_select = 1'b0, qie_reset_source = 1'b0;
    logic wte_in = 1'b0, qie_reset_in = 1'b0, aux_in = 1'b1, ext_clk_in = 1'b0, clk_in_j1 = 1'b0;
    logic clk_out_p2, qie_reset_out, penable, reset_out, wte_out, aux_out;
    int   n_chk = 0, n_pass = 0;
    logic found;
    logic [15:0] gate_exp;

    control_emulator dut (
        .int_clk_in(clk), .reset_switch(reset_switch), .pgood(pgood),
        .clk_select(clk_select), .mode_select(mode_select),
        .qie_reset_source(qie_reset_source), .wte_in(wte_in),
        .qie_reset_in(qie_reset_in), .aux_in(aux_in), .ext_clk_in(ext_clk_in),
        .clk_in_j1(clk_in_j1), .clk_out_p2(clk_out_p2), .qie_reset_out(qie_reset_out),
        .penable(penable), .reset_out(reset_out), .wte_out(wte_out), .aux_out(aux_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit k of each pattern is the input before edge k+1 / the output after it.
    task automatic run(input logic [15:0] pm, pw, pq, pa, ew, eq, ea, input int n);
        for (int k = 0; k < n; k++) begin
            mode_select  = pm[k];
            wte_in       = pw[k];
            qie_reset_in = pq[k];
            aux_in       = pa[k];
            tick();
            chk($sformatf("wte%0d", k), wte_out, ew[k]);
            chk($sformatf("qie%0d", k), qie_reset_out, eq[k]);
            chk($sformatf("aux%0d", k), aux_out, ea[k]);
        end
    endtask

    initial begin
        #2 reset_switch = 1'b0;
        repeat (5) tick();
        chk("rst_reset_out", reset_out, 1);
        chk("rst_wte", wte_out, 0);
        chk("rst_qie", qie_reset_out, 0);
        chk("rst_penable", penable, 0);
        chk("rst_aux", aux_out, 1);
        mode_select = 1'b1;
        clk_in_j1   = 1'b1;
        #1 chk("rst_mux", clk_out_p2, 1);
        clk_in_j1   = 1'b0;
        mode_select = 1'b0;
        tick();
        reset_switch = 1'b1;
        pgood        = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("stretch%0d", k), reset_out, k < 8);
            chk($sformatf("pen%0d", k), penable, k >= 8);
        end
        run(16'h0, 16'h7, 16'h7, ~16'h7, 16'h1C, 16'h1C, ~16'h1C, 10);
        run(16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 3);
        run(16'hFFFF, 16'h1, 16'h5, 16'hFFFF, 16'h3C, 16'hFC, 16'hFFFF, 12);
        run(16'hFFFF, 16'h5, 16'h1, 16'hFFFF, 16'hFC, 16'h3C, 16'hFFFF, 12);
        run(16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 2);
        run(16'h000F, 16'h1, 16'h1, 16'hFFFF, 16'hC, 16'hC, 16'hFFFF, 10);
        pgood = 1'b0;
        tick();
        chk("pgood_fall1", penable, 1);
        tick();
        chk("pgood_fall2", penable, 0);
`ifdef CTRL_EMU_PGOOD_GATE_EN
        gate_exp = 16'h0;
`else
        gate_exp = 16'h3C;
`endif
        run(16'hFFFF, 16'h1, 16'h0, 16'hFFFF, gate_exp, 16'h0, 16'hFFFF, 8);
        pgood = 1'b1;
        repeat (3) tick();
        chk("pgood_back", penable, 1);
        wte_in = 1'b1;
        aux_in = 1'b0;
        repeat (3) tick();
        chk("abort_pre", wte_out, 1);
        #2 reset_switch = 1'b0;
        #1;
        chk("abort_wte", wte_out, 0);
        chk("abort_reset_out", reset_out, 1);
        chk("abort_pen", penable, 0);
        chk("abort_aux", aux_out, 1);
        wte_in = 1'b0;
        aux_in = 1'b1;
        tick();
        reset_switch = 1'b1;
        repeat (8) tick();
        chk("abort_release", reset_out, 0);
        chk("abort_wte_after", wte_out, 0);
        mode_select      = 1'b0;
        qie_reset_source = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            qie_reset_in = ~qie_reset_in;
            tick();
            found = qie_reset_out;
        end
        chk("orbit_found", found, 1);
        for (int k = 1; k <= 32; k++) begin
            qie_reset_in = ~qie_reset_in;
            tick();
            chk($sformatf("orbit%0d", k), qie_reset_out, (k % 16) == 0);
        end
        qie_reset_source = 1'b0;
        qie_reset_in     = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mode_select = c[1];
            clk_select  = c[0];
            for (int v = 0; v < 4; v++) begin
                ext_clk_in = v[0];
                clk_in_j1  = v[1];
                #5;
                chk($sformatf("mux%0d_%0d", c, v), clk_out_p2,
                    c[1] ? clk_in_j1 : c[0] ? ext_clk_in : clk);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/control_emulator.md
Name: control_emulator

Overview:
- Emulates the ngCCM control block for front-end bench testing.
- Conditions the front-panel control inputs (WTE, QIE reset, AUX, power-good) into the `int_clk_in` domain.
- Drives them onward in level pass-through or one-shot pulse mode.
- Muxes one of three clock sources onto the P2 clock output.

Parameters:
- PULSE_LEN, 4: width in clocks of one-shot pulses in pulse mode; legal range 1..255.
- ORBIT_LEN, 16: period in clocks of the internally generated QIE reset; legal range 2..65535.
- RESET_STRETCH, 8: number of clocks `reset_out` stays high after reset release; legal range 1..255.

Ports:
- int_clk_in  in  1  single system clock; all registers are on its rising edge.
- reset_switch  in  1  asynchronous active-low reset (front-panel switch).
- pgood  in  1  power-good, asynchronous.
- clk_select  in  1  clock source select, static.
- mode_select  in  1  0 = level pass-through, 1 = pulse mode; may change at any time.
- qie_reset_source  in  1  0 = external `qie_reset_in`, 1 = internal periodic generator.
- wte_in  in  1  warning-test-enable, asynchronous.
- qie_reset_in  in  1  external QIE reset, asynchronous.
- aux_in  in  1  auxiliary line, asynchronous, idles high.
- ext_clk_in  in  1  external clock, used only as mux data.
- clk_in_j1  in  1  J1 connector clock, used only as mux data.
- clk_out_p2  out  1  muxed clock.
- qie_reset_out  out  1  QIE reset out.
- penable  out  1  power enable.
- reset_out  out  1  active-high stretched reset.
- wte_out  out  1  WTE out.
- aux_out  out  1  AUX out.

Behaviour:
- Reset (`reset_switch`=0, asynchronous):
  - All registers clear.
  - `reset_out`=1; `wte_out`, `qie_reset_out`, `penable` = 0; `aux_out`=1.
  - Synchronizer stages are preset to idle: aux to 1, all others to 0.
- Reset release: `reset_out` stays 1 for exactly RESET_STRETCH rising edges after `reset_switch` rises, then goes 0.
- Reset asserted mid-operation: all outputs return to their reset values immediately and any pulse or count is aborted.
- Synchronizers: `wte_in`, `qie_reset_in`, `aux_in` and `pgood` each pass through 2 flops (s1, s2). A third flop s3 holds the previous s2 for edge detection.
- `penable` = s2 of `pgood` (2-cycle latency), forced 0 while `reset_out`=1.
- `aux_out` = registered s2 of `aux_in` in both modes (3-cycle latency).
- mode_select=0 (pass-through): `wte_out` and the external QIE path are registered s2 levels. An input change appears at the output on the 3rd rising edge.
- mode_select=1 (pulse mode):
  - A rising edge (s2 & ~s3) loads an 8-bit down-counter with PULSE_LEN.
  - The output is high while the counter is nonzero, so it goes high on the 3rd edge after the input rises and stays high exactly PULSE_LEN clocks.
  - A new rising edge during an active pulse reloads the counter (retrigger, extends the pulse).
  - Falling edges are ignored.
- QIE reset source:
  - `qie_reset_source`=0: `qie_reset_out` follows the external path in the current mode.
  - `qie_reset_source`=1: a 16-bit counter runs 0..ORBIT_LEN-1 from reset release. `qie_reset_out` is registered high for 1 clock when count = ORBIT_LEN-1, and `qie_reset_in` is ignored. The counter runs regardless of `qie_reset_source`.
- Mode change mid-pulse: switching to mode 0 clears the pulse counters and outputs take the level path on the next edge.
- Clock mux (combinational, no glitch protection required):
  - mode_select=1: `clk_out_p2` = `clk_in_j1`.
  - mode_select=0 and clk_select=0: `clk_out_p2` = `int_clk_in`.
  - mode_select=0 and clk_select=1: `clk_out_p2` = `ext_clk_in`.
  - During reset the mux stays active.

Optional Feature:
- CTRL_EMU_PGOOD_GATE_EN defined: `wte_out` and `qie_reset_out` are ANDed with `penable` (forced 0 while power is not good). The pulse counters keep running internally.
- Not defined: `wte_out` and `qie_reset_out` are independent of `pgood`; `penable` behaviour is unchanged.

Test Plan:
- Reset: hold `reset_switch`=0 for 5 clocks, then release → outputs at reset values during reset; `reset_out` drops exactly 8 clocks after release; `penable`=1 2 clocks after `pgood`=1 once `reset_out`=0.
- Pass-through (mode 0): `wte_in` high for 3 clocks → `wte_out` high 3 clocks, starting on the 3rd edge; `aux_in` low for 3 clocks → `aux_out` low 3 clocks, 3-cycle latency.
- Pulse mode (mode 1): `wte_in` high for 1 clock → `wte_out` high exactly 4 clocks; second rise 2 clocks later → pulse extended to end 4 clocks after that rise; `qie_reset_in` behaves the same.
- Internal QIE reset: `qie_reset_source`=1 → `qie_reset_out` is a 1-clock pulse every 16 clocks; toggling `qie_reset_in` has no effect.
- Clock mux: cycle (mode_select, clk_select) through 00/01/10/11 → `clk_out_p2` matches `int_clk_in`, `ext_clk_in`, `clk_in_j1`, `clk_in_j1` respectively.
- With CTRL_EMU_PGOOD_GATE_EN: `pgood`=0 and a WTE pulse applied → `wte_out` stays 0; without the macro, `wte_out` pulses normally.
